// File: rtl/mnist_pkg.sv
// rtl/mnist_pkg.sv - shared classifier constants, score vector type and argmax helpers
package mnist_pkg;

   localparam int NUM_CLASSES = 10;
   localparam int SCORE_W     = 8;
   localparam int DIGIT_W     = 4;
   localparam int ARGMAX_LAT  = 4;

   // One score per class; element k is the score of class k
   typedef logic [0:NUM_CLASSES-1][SCORE_W-1:0] score_vec_t;

   // Candidate carried through the argmax tree: best score so far and its class
   typedef struct packed {
      logic [SCORE_W-1:0] val;
      logic [DIGIT_W-1:0] idx;
   } cand_t;

   // Callers always pass the lower-index candidate as a, so ties keep a
   function automatic cand_t pick_max(input cand_t a, input cand_t b);
      return (b.val > a.val) ? b : a;
   endfunction

   // Width of a requester index; a single requester still needs one bit
   function automatic int src_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/argmax_scheduler_if.sv
// rtl/argmax_scheduler_if.sv - requester and result bundle of the shared argmax scheduler
interface argmax_scheduler_if
   import mnist_pkg::*;
#(
   parameter int N_REQ = 2
) ();

   localparam int SRC_W = src_width(N_REQ);

   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   score_vec_t [N_REQ-1:0] req_score;
   logic                   res_valid;
   logic                   res_ready;
   logic [DIGIT_W-1:0]     res_digit;
   logic [SRC_W-1:0]       res_src;
   logic [15:0]            frame_count;
   logic                   busy;

   // Scheduler side
   modport slave (
      input  req_valid, req_score, res_ready,
      output req_ready, res_valid, res_digit, res_src, frame_count, busy
   );

   // Producer / consumer side
   modport master (
      output req_valid, req_score, res_ready,
      input  req_ready, res_valid, res_digit, res_src, frame_count, busy
   );

endinterface

// File: rtl/max_value_index.sv
// rtl/max_value_index.sv - four-stage argmax over ten 8-bit scores, ties to the lower class
module max_value_index
   import mnist_pkg::*;
(
   input  logic               clk,
   input  score_vec_t         score,
   output logic [DIGIT_W-1:0] digit
);

   cand_t              s1_d [5];
   cand_t              s1_q [5];
   cand_t              s2_d [3];
   cand_t              s2_q [3];
   cand_t              s3_d [2];
   cand_t              s3_q [2];
   logic [DIGIT_W-1:0] digit_d;
   logic [DIGIT_W-1:0] digit_q;

   // Reduction tree 10 -> 5 -> 3 -> 2 -> 1; left operand always holds the lower classes
   always_comb begin
      for (int k = 0; k < 5; k++) begin
         s1_d[k] = pick_max(cand_t'{val: score[2*k],   idx: DIGIT_W'(2*k)},
                            cand_t'{val: score[2*k+1], idx: DIGIT_W'(2*k+1)});
      end
      s2_d[0] = pick_max(s1_q[0], s1_q[1]);
      s2_d[1] = pick_max(s1_q[2], s1_q[3]);
      s2_d[2] = s1_q[4];
      s3_d[0] = pick_max(s2_q[0], s2_q[1]);
      s3_d[1] = s2_q[2];
      digit_d = pick_max(s3_q[0], s3_q[1]).idx;
   end

   // Data-only pipeline registers; validity is tracked by the caller, so no reset
   always_ff @(posedge clk) begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      digit_q <= digit_d;
   end

   assign digit = digit_q;

endmodule

// File: rtl/argmax_scheduler.sv
// rtl/argmax_scheduler.sv - round-robin, credit-gated sharing of one argmax pipeline with a result FIFO
module argmax_scheduler
   import mnist_pkg::*;
#(
   parameter int N_REQ      = 2,
   parameter int FIFO_DEPTH = 8,
   parameter int LAT        = ARGMAX_LAT
) (
   input logic               clk,
   input logic               rst_n,
   argmax_scheduler_if.slave bus
);

   localparam int SRC_W = src_width(N_REQ);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Arbiter / launch
   logic [SRC_W-1:0]   last_d, last_q;
   logic [SRC_W-1:0]   grant_idx;
   logic               grant_found;
   logic               credit_ok;
   logic               launch_ok;
   logic               handshake;
   int                 inflight;
   score_vec_t         pipe_in;
   logic [DIGIT_W-1:0] pipe_digit;

   // Tag shift register
   logic [LAT-1:0]     tag_v_d, tag_v_q;
   logic [SRC_W-1:0]   tag_src_d [LAT];
   logic [SRC_W-1:0]   tag_src_q [LAT];

   // Result FIFO
   logic [DIGIT_W-1:0] mem_digit_d [FIFO_DEPTH];
   logic [DIGIT_W-1:0] mem_digit_q [FIFO_DEPTH];
   logic [SRC_W-1:0]   mem_src_d   [FIFO_DEPTH];
   logic [SRC_W-1:0]   mem_src_q   [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_d, wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_d, rd_ptr_q;
   logic [CNT_W-1:0]   occ_d, occ_q;
   logic [15:0]        frame_count_d, frame_count_q;
   logic               push;
   logic               pop;
   logic               res_valid;

   // Credit: results already owed (in flight) plus results held must leave a free slot
   always_comb begin
      inflight = 0;
      for (int s = 0; s < LAT; s++) begin
         inflight = inflight + int'(tag_v_q[s]);
      end
      credit_ok = (inflight + int'(occ_q)) < FIFO_DEPTH;
   end

   // Round-robin search starting one past the last granted requester
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!grant_found && bus.req_valid[(int'(last_q) + k) % N_REQ]) begin
            grant_found = 1'b1;
            grant_idx   = SRC_W'((int'(last_q) + k) % N_REQ);
         end
      end
   end

   // Held in reset, the grant is suppressed so req_ready reads 0 immediately
   assign launch_ok     = rst_n & credit_ok & grant_found;
   assign bus.req_ready = launch_ok ? (N_REQ'(1) << grant_idx) : '0;
   assign handshake     = |(bus.req_valid & bus.req_ready);
   assign pipe_in       = handshake ? bus.req_score[grant_idx] : '0;

   max_value_index u_argmax (
      .clk   (clk),
      .score (pipe_in),
      .digit (pipe_digit)
   );

   // Next state of arbiter pointer and tag shift register
   always_comb begin
      last_d       = handshake ? grant_idx : last_q;
      tag_v_d[0]   = handshake;
      tag_src_d[0] = grant_idx;
      for (int s = 1; s < LAT; s++) begin
         tag_v_d[s]   = tag_v_q[s-1];
         tag_src_d[s] = tag_src_q[s-1];
      end
   end

   assign push      = tag_v_q[LAT-1];
   assign res_valid = (occ_q != '0);
   assign pop       = res_valid & bus.res_ready;

   // FIFO pointers, occupancy, storage and pop counter
   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      occ_d         = occ_q;
      frame_count_d = frame_count_q;
      mem_digit_d   = mem_digit_q;
      mem_src_d     = mem_src_q;
      if (push) begin
         mem_digit_d[wr_ptr_q] = pipe_digit;
         mem_src_d[wr_ptr_q]   = tag_src_q[LAT-1];
         wr_ptr_d              = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d      = rd_ptr_q + 1'b1;
         frame_count_d = frame_count_q + 16'd1;
      end
      case ({push, pop})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
   end

   // Control state; everything that decides validity is cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q        <= SRC_W'(N_REQ - 1);
         tag_v_q       <= '0;
         for (int s = 0; s < LAT; s++) begin
            tag_src_q[s] <= '0;
         end
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         occ_q         <= '0;
         frame_count_q <= '0;
      end else begin
         last_q        <= last_d;
         tag_v_q       <= tag_v_d;
         tag_src_q     <= tag_src_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         occ_q         <= occ_d;
         frame_count_q <= frame_count_d;
      end
   end

   // FIFO storage; contents only matter where occupancy says so
   always_ff @(posedge clk) begin
      mem_digit_q <= mem_digit_d;
      mem_src_q   <= mem_src_d;
   end

   // Head is forced to zero when empty so outputs have defined reset values
   assign bus.res_valid   = res_valid;
   assign bus.res_digit   = res_valid ? mem_digit_q[rd_ptr_q] : '0;
   assign bus.res_src     = res_valid ? mem_src_q[rd_ptr_q] : '0;
   assign bus.frame_count = frame_count_q;
   assign bus.busy        = (|tag_v_q) | res_valid;

endmodule
